// File: rtl/csr_trap_unit_if.sv
// CSR access bus between the instruction pipeline (master) and csr_trap_unit (slave).
// Read data and the illegal flag are combinational on the current address and operation.
interface csr_trap_unit_if;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;

  modport master (
    output csr_addr_i, csr_op_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_addr_i, csr_op_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/mret, interrupt arbitration and 64-bit counters.
// Optional feature macro: CSR_VECTORED_MTVEC_EN (vectored mtvec mode for interrupts).
module csr_trap_unit #(
  parameter int          NUM_HPM     = 4,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  csr_trap_unit_if.slave       csr,
  input  logic                 trap_valid_i,
  input  logic [31:0]          trap_pc_i,
  input  logic [31:0]          trap_cause_i,
  input  logic [31:0]          trap_val_i,
  input  logic                 mret_i,
  input  logic                 ext_irq_i,
  input  logic                 timer_irq_i,
  input  logic                 sw_irq_i,
  input  logic                 instret_i,
  input  logic [NUM_HPM-1:0]   hpm_event_i,
  output logic [31:0]          trap_vector_o,
  output logic [31:0]          epc_o,
  output logic                 irq_pending_o,
  output logic [31:0]          irq_cause_o
);

  typedef enum logic [1:0] {OP_NONE, OP_RW, OP_RS, OP_RC} csr_op_e;

  localparam int          HPM_N     = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] CINH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
  localparam logic [31:0] MIE_MASK  = 32'h0000_0888;

  function automatic logic [31:0] legal_mtvec(input logic [31:0] v);
`ifdef CSR_VECTORED_MTVEC_EN
    legal_mtvec = (v[1:0] == 2'b01) ? v : {v[31:2], 2'b00};
`else
    legal_mtvec = {v[31:2], 2'b00};
`endif
  endfunction

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mcountinhibit_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;
  logic [63:0] hpm_q [HPM_N];

  logic [31:0] mstatus_val, mip_val, rdata, wval;
  logic [63:0] cnt_val;
  logic        impl, read_only, wr_req, illegal, we, cnt_we;
  logic        cnt_range, cnt_hi, cnt_shadow;
  logic [4:0]  cnt_idx;
  csr_op_e     op;

  assign op          = csr_op_e'(csr.csr_op_i);
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mip_val     = {20'b0, ext_irq_i, 3'b0, timer_irq_i, 3'b0, sw_irq_i, 3'b0};

  // Counter window: 0xB00-0xB1F / 0xB80-0xB9F and read-only shadows at 0xCxx.
  assign cnt_range  = ((csr.csr_addr_i[11:8] == 4'hB) || (csr.csr_addr_i[11:8] == 4'hC)) &&
                      (csr.csr_addr_i[6:5] == 2'b00);
  assign cnt_idx    = csr.csr_addr_i[4:0];
  assign cnt_hi     = csr.csr_addr_i[7];
  assign cnt_shadow = (csr.csr_addr_i[11:8] == 4'hC);

  // NOTE: every signal written in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_val = '0;
    if (cnt_idx == 5'd0) cnt_val = mcycle_q;
    else if (cnt_idx == 5'd2) cnt_val = minstret_q;
    for (int k = 0; k < NUM_HPM; k++) begin
      if (cnt_idx == 5'(k + 3)) cnt_val = hpm_q[k];
    end
  end

  always_comb begin
    rdata     = '0;
    impl      = 1'b0;
    read_only = 1'b0;
    case (csr.csr_addr_i)
      12'h300: begin impl = 1'b1; rdata = mstatus_val;     end
      12'h301: begin impl = 1'b1;                          end
      12'h304: begin impl = 1'b1; rdata = mie_q;           end
      12'h305: begin impl = 1'b1; rdata = mtvec_q;         end
      12'h320: begin impl = 1'b1; rdata = mcountinhibit_q; end
      12'h340: begin impl = 1'b1; rdata = mscratch_q;      end
      12'h341: begin impl = 1'b1; rdata = mepc_q;          end
      12'h342: begin impl = 1'b1; rdata = mcause_q;        end
      12'h343: begin impl = 1'b1; rdata = mtval_q;         end
      12'h344: begin impl = 1'b1; read_only = 1'b1; rdata = mip_val; end
      12'hF14: begin impl = 1'b1; read_only = 1'b1; rdata = HART_ID; end
      default: begin
        // Index 1 (time) has no machine-mode counter; only its user shadow exists.
        if (cnt_range && !(cnt_idx == 5'd1 && !cnt_shadow)) begin
          impl      = 1'b1;
          read_only = cnt_shadow;
          rdata     = cnt_hi ? cnt_val[63:32] : cnt_val[31:0];
        end
      end
    endcase
  end

  always_comb begin
    wval = rdata;
    case (op)
      OP_RW:   wval = csr.csr_wdata_i;
      OP_RS:   wval = rdata | csr.csr_wdata_i;
      OP_RC:   wval = rdata & ~csr.csr_wdata_i;
      default: wval = rdata;
    endcase
  end

  assign wr_req  = (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && (csr.csr_wdata_i != '0));
  assign illegal = (op != OP_NONE) && (!impl || (wr_req && read_only));
  assign we      = wr_req && !illegal && !trap_valid_i && !mret_i;
  assign cnt_we  = we && cnt_range && !cnt_shadow;

  assign csr.csr_rdata_o   = rdata;
  assign csr.csr_illegal_o = illegal;
  assign epc_o             = {mepc_q[31:1], 1'b0};

  logic [31:0] irq_enabled;
  assign irq_enabled   = mip_val & mie_q;
  assign irq_pending_o = mstatus_mie && (irq_enabled != '0);

  always_comb begin
    irq_cause_o = '0;
    if (irq_pending_o) begin
      if (irq_enabled[11])     irq_cause_o = 32'h8000_000B;
      else if (irq_enabled[3]) irq_cause_o = 32'h8000_0003;
      else if (irq_enabled[7]) irq_cause_o = 32'h8000_0007;
    end
  end

  always_comb begin
    trap_vector_o = {mtvec_q[31:2], 2'b00};
`ifdef CSR_VECTORED_MTVEC_EN
    if ((mtvec_q[1:0] == 2'b01) && mcause_q[31])
      trap_vector_o = {mtvec_q[31:2], 2'b00} + {25'b0, mcause_q[4:0], 2'b00};
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie     <= 1'b0;
      mstatus_mpie    <= 1'b0;
      mie_q           <= '0;
      mtvec_q         <= legal_mtvec(MTVEC_RESET);
      mcountinhibit_q <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mcycle_q        <= '0;
      minstret_q      <= '0;
      // NOTE: the counter array is architectural state, so it is cleared element by element rather than left unreset like a data RAM.
      for (int k = 0; k < HPM_N; k++) hpm_q[k] <= '0;
    end else begin
      if (trap_valid_i) begin
        mepc_q       <= trap_pc_i;
        mcause_q     <= trap_cause_i;
        mtval_q      <= trap_val_i;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (we) begin
        case (csr.csr_addr_i)
          12'h300: begin mstatus_mie <= wval[3]; mstatus_mpie <= wval[7]; end
          12'h304: mie_q           <= wval & MIE_MASK;
          12'h305: mtvec_q         <= legal_mtvec(wval);
          12'h320: mcountinhibit_q <= wval & CINH_MASK;
          12'h340: mscratch_q      <= wval;
          12'h341: mepc_q          <= wval;
          12'h342: mcause_q        <= wval;
          12'h343: mtval_q         <= wval;
          default: ;
        endcase
      end

      // A write to either half replaces this cycle's increment for the whole counter.
      if (cnt_we && cnt_idx == 5'd0)
        mcycle_q <= cnt_hi ? {wval, mcycle_q[31:0]} : {mcycle_q[63:32], wval};
      else if (!mcountinhibit_q[0])
        mcycle_q <= mcycle_q + 64'd1;

      if (cnt_we && cnt_idx == 5'd2)
        minstret_q <= cnt_hi ? {wval, minstret_q[31:0]} : {minstret_q[63:32], wval};
      else if (!mcountinhibit_q[2])
        minstret_q <= minstret_q + 64'(instret_i);

      for (int k = 0; k < NUM_HPM; k++) begin
        if (cnt_we && cnt_idx == 5'(k + 3))
          hpm_q[k] <= cnt_hi ? {wval, hpm_q[k][31:0]} : {hpm_q[k][63:32], wval};
        else if (!mcountinhibit_q[k + 3] && hpm_event_i[k])
          hpm_q[k] <= hpm_q[k] + 64'd1;
      end
    end
  end

endmodule
